// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD nibble writer: state encoding,
// default interface timing and delay-counter sizing helpers.
package lcd_pkg;

  typedef enum logic [3:0] {
    IDLE,
    HI_SETUP,
    HI_EN,
    HI_HOLD,
    GAP,
    LO_SETUP,
    LO_EN,
    LO_HOLD,
    CMD_WAIT
  } lcd_state_e;

  localparam int unsigned T_SETUP_DEF = 2;
  localparam int unsigned T_EHIGH_DEF = 12;
  localparam int unsigned T_HOLD_DEF  = 1;
  localparam int unsigned T_GAP_DEF   = 50;
  localparam int unsigned T_CMD_DEF   = 2000;

  localparam int unsigned CNT_MIN_W = 16;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Counter never narrower than 16 bits, wider only if a phase needs it.
  function automatic int unsigned cnt_width(input int unsigned longest);
    return max2(CNT_MIN_W, $clog2(longest + 1));
  endfunction

endpackage

// File: rtl/lcd_nibble_writer.sv
// Writes one byte to an HD44780-style LCD over a 4-bit bus as two E-strobed
// nibbles (high then low), with a settle period before the next accept.
module lcd_nibble_writer
  import lcd_pkg::*;
#(
  parameter int unsigned T_SETUP = T_SETUP_DEF,
  parameter int unsigned T_EHIGH = T_EHIGH_DEF,
  parameter int unsigned T_HOLD  = T_HOLD_DEF,
  parameter int unsigned T_GAP   = T_GAP_DEF,
  parameter int unsigned T_CMD   = T_CMD_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [3:0] lcd_dat
);

  localparam int unsigned T_LONGEST =
    max2(max2(max2(T_SETUP, T_EHIGH), max2(T_HOLD, T_GAP)), T_CMD);
  localparam int unsigned CW = cnt_width(T_LONGEST);

  lcd_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rs_q, rs_d;
  logic [3:0]    dat_q, dat_d;
  logic [3:0]    lo_q, lo_d;
  logic          e_q, e_d;

  // Counter load on entry: a phase lasting T cycles counts T-1 down to 0.
  function automatic logic [CW-1:0] dur(input lcd_state_e s);
    logic [CW-1:0] d;
    case (s)
      HI_SETUP, LO_SETUP: d = CW'(T_SETUP - 1);
      HI_EN, LO_EN:       d = CW'(T_EHIGH - 1);
      HI_HOLD, LO_HOLD:   d = CW'(T_HOLD - 1);
      GAP:                d = CW'(T_GAP - 1);
      CMD_WAIT:           d = CW'(T_CMD - 1);
      default:            d = '0;
    endcase
    return d;
  endfunction

  function automatic lcd_state_e succ(input lcd_state_e s);
    lcd_state_e n;
    case (s)
      HI_SETUP: n = HI_EN;
      HI_EN:    n = HI_HOLD;
      HI_HOLD:  n = GAP;
      GAP:      n = LO_SETUP;
      LO_SETUP: n = LO_EN;
      LO_EN:    n = LO_HOLD;
      LO_HOLD:  n = CMD_WAIT;
      default:  n = IDLE;
    endcase
    return n;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rs_d    = rs_q;
    dat_d   = dat_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (wr_valid) begin
          state_d = HI_SETUP;
          cnt_d   = dur(HI_SETUP);
          rs_d    = wr_rs;
          dat_d   = wr_data[7:4];
          lo_d    = wr_data[3:0];
        end
      end
      default: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = succ(state_q);
          cnt_d   = dur(state_d);
          if (state_d == LO_SETUP) begin
            dat_d = lo_q;
          end
        end
      end
    endcase
    // E is registered from the next state so the pin has no decode glitches.
    e_d = (state_d == HI_EN) || (state_d == LO_EN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rs_q    <= 1'b0;
      dat_q   <= '0;
      lo_q    <= '0;
      e_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
      dat_q   <= dat_d;
      lo_q    <= lo_d;
      e_q     <= e_d;
    end
  end

  assign wr_ready = (state_q == IDLE);
  assign lcd_rs   = rs_q;
  assign lcd_rw   = 1'b0;
  assign lcd_e    = e_q;
  assign lcd_dat  = dat_q;

endmodule
